// File: rtl/game_state_ctrl.sv
// Screen/game sequencer: TITLE/PLAYING/PAUSED/OVER FSM, end-of-frame tick, BCD score and high score.
// Optional build macro GAMEOVER_AUTORETURN_EN: leave OVER after GAMEOVER_FRAMES frames.
module game_state_ctrl #(
  parameter int unsigned FRAME_Y         = 481,
  parameter int unsigned SCORE_DIGITS    = 4,
  parameter int unsigned GAMEOVER_FRAMES = 180
) (
  input  logic                      clk_100MHz,
  input  logic                      reset,
  input  logic                      p_tick,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      game_over,
  input  logic                      alien_hit,
  output logic [1:0]                state,
  output logic                      game_freeze,
  output logic                      game_reset,
  output logic [1:0]                screen_sel,
  output logic                      frame_tick,
  output logic [1:0]                frame_cnt,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score
);

  localparam int unsigned SCORE_W = 4 * SCORE_DIGITS;

  localparam logic [1:0] ST_TITLE   = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  localparam logic [1:0] SEL_TITLE = 2'd0;
  localparam logic [1:0] SEL_GAME  = 2'd1;
  localparam logic [1:0] SEL_OVER  = 2'd2;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

  logic [1:0]         state_q, state_d;
  logic               freeze_q, freeze_d;
  logic               game_reset_q, game_reset_d;
  logic [1:0]         sel_q, sel_d;
  logic               frame_tick_q, frame_tick_d;
  logic [1:0]         frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_score_q, hi_score_d;
  logic               start_q;
  logic               start_rise_c;
  logic               autoreturn_c;

  // Decimal increment with ripple carry across BCD digits
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_rise_c = start & ~start_q;

`ifdef GAMEOVER_AUTORETURN_EN
  localparam int unsigned GO_CNT_W = $clog2(GAMEOVER_FRAMES + 1) + 1;

  logic [GO_CNT_W-1:0] go_cnt_q, go_cnt_d;

  // Held at zero outside OVER, so every entry into OVER starts a fresh count
  always_comb begin
    go_cnt_d = go_cnt_q;
    if (state_q != ST_OVER) begin
      go_cnt_d = '0;
    end else if (frame_tick_q && (go_cnt_q < GO_CNT_W'(GAMEOVER_FRAMES))) begin
      go_cnt_d = go_cnt_q + GO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      go_cnt_q <= '0;
    end else begin
      go_cnt_q <= go_cnt_d;
    end
  end

  assign autoreturn_c = (go_cnt_q >= GO_CNT_W'(GAMEOVER_FRAMES));
`else
  logic unused_gameover_frames;

  assign unused_gameover_frames = |32'(GAMEOVER_FRAMES);
  assign autoreturn_c           = 1'b0;
`endif

  // Next-state logic; the restart pulse fires on the TITLE -> PLAYING edge
  always_comb begin
    state_d      = state_q;
    game_reset_d = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (start_rise_c) begin
          state_d      = ST_PLAYING;
          game_reset_d = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (!start) begin
          state_d = ST_TITLE;
        end else if (game_over) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!start) begin
          state_d = ST_TITLE;
        end else if (!pause) begin
          state_d = ST_PLAYING;
        end
      end
      ST_OVER: begin
        if (!start || autoreturn_c) begin
          state_d = ST_TITLE;
        end
      end
      default: state_d = ST_TITLE;
    endcase
  end

  // Moore outputs decoded from the next state so they change with state
  always_comb begin
    freeze_d = 1'b1;
    sel_d    = SEL_TITLE;
    case (state_d)
      ST_TITLE:   begin freeze_d = 1'b1; sel_d = SEL_TITLE; end
      ST_PLAYING: begin freeze_d = 1'b0; sel_d = SEL_GAME;  end
      ST_PAUSED:  begin freeze_d = 1'b1; sel_d = SEL_GAME;  end
      ST_OVER:    begin freeze_d = 1'b1; sel_d = SEL_OVER;  end
      default:    begin freeze_d = 1'b1; sel_d = SEL_TITLE; end
    endcase
  end

  // Frame tick and free-running 2-bit frame counter advance together
  always_comb begin
    frame_tick_d = p_tick && (y == 10'(FRAME_Y)) && (x == 10'd0);
    frame_cnt_d  = frame_cnt_q + 2'(frame_tick_d);
  end

  // Score counts kills only while playing, saturating at all nines
  always_comb begin
    score_d    = score_q;
    hi_score_d = hi_score_q;
    if ((state_q == ST_TITLE) && start_rise_c) begin
      score_d = '0;
    end else if ((state_q == ST_PLAYING) && alien_hit && (score_q != SCORE_MAX)) begin
      score_d = bcd_inc(score_q);
    end
    if ((state_q == ST_OVER) && (score_q > hi_score_q)) begin
      hi_score_d = score_q;
    end
  end

  // start_q resets high so a switch left on through reset does not start a game
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= ST_TITLE;
      freeze_q     <= 1'b1;
      game_reset_q <= 1'b0;
      sel_q        <= SEL_TITLE;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= 2'd0;
      score_q      <= '0;
      hi_score_q   <= '0;
      start_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      freeze_q     <= freeze_d;
      game_reset_q <= game_reset_d;
      sel_q        <= sel_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      score_q      <= score_d;
      hi_score_q   <= hi_score_d;
      start_q      <= start;
    end
  end

  assign state       = state_q;
  assign game_freeze = freeze_q;
  assign game_reset  = game_reset_q;
  assign screen_sel  = sel_q;
  assign frame_tick  = frame_tick_q;
  assign frame_cnt   = frame_cnt_q;
  assign score       = score_q;
  assign hi_score    = hi_score_q;

endmodule
